// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, funct3, ALU ops,
// immediate formats, datapath mux selects and the controller state enum.
package multicycle_controller_pkg;

   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcRtype  = 7'b0110011;
   localparam logic [6:0] OpcItype  = 7'b0010011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcXorid  = 7'b0001011;

   localparam logic [2:0] F3AddSub = 3'b000;
   localparam logic [2:0] F3Sll    = 3'b001;
   localparam logic [2:0] F3Slt    = 3'b010;
   localparam logic [2:0] F3Sltu   = 3'b011;
   localparam logic [2:0] F3Xor    = 3'b100;
   localparam logic [2:0] F3SrlSra = 3'b101;
   localparam logic [2:0] F3Or     = 3'b110;
   localparam logic [2:0] F3And    = 3'b111;

   localparam logic [2:0] F3Beq  = 3'b000;
   localparam logic [2:0] F3Bne  = 3'b001;
   localparam logic [2:0] F3Blt  = 3'b100;
   localparam logic [2:0] F3Bge  = 3'b101;
   localparam logic [2:0] F3Bltu = 3'b110;
   localparam logic [2:0] F3Bgeu = 3'b111;

   localparam logic [3:0] AluAdd  = 4'b0000;
   localparam logic [3:0] AluSub  = 4'b0001;
   localparam logic [3:0] AluSlt  = 4'b0010;
   localparam logic [3:0] AluSltu = 4'b0011;
   localparam logic [3:0] AluXor  = 4'b0100;
   localparam logic [3:0] AluOr   = 4'b0101;
   localparam logic [3:0] AluAnd  = 4'b0110;
   localparam logic [3:0] AluSll  = 4'b0111;
   localparam logic [3:0] AluSrl  = 4'b1000;
   localparam logic [3:0] AluSra  = 4'b1001;

   localparam logic [2:0] ImmI    = 3'b000;
   localparam logic [2:0] ImmS    = 3'b001;
   localparam logic [2:0] ImmB    = 3'b010;
   localparam logic [2:0] ImmU    = 3'b011;
   localparam logic [2:0] ImmJ    = 3'b100;
   localparam logic [2:0] ImmNone = 3'b111;

   localparam logic [1:0] SrcAPc    = 2'b00;
   localparam logic [1:0] SrcAOldPc = 2'b01;
   localparam logic [1:0] SrcARs1   = 2'b10;
   localparam logic [1:0] SrcBRs2   = 2'b00;
   localparam logic [1:0] SrcBImm   = 2'b01;
   localparam logic [1:0] SrcBFour  = 2'b10;

   localparam logic [1:0] ResAluOut = 2'b00;
   localparam logic [1:0] ResMem    = 2'b01;
   localparam logic [1:0] ResAlu    = 2'b10;
   localparam logic [1:0] ResImm    = 2'b11;

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExeR,
      StExeI, StAluWb, StBranch, StJal, StJalr, StUpper, StTrap
   } state_e;

   function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                         input logic lt, input logic ltu);
      logic t;
      case (funct3)
         F3Beq:   t = zero;
         F3Bne:   t = !zero;
         F3Blt:   t = lt;
         F3Bge:   t = !lt;
         F3Bltu:  t = ltu;
         F3Bgeu:  t = !ltu;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from funct3 and instr[30]; SUB is only honoured for R-type,
// the SRL/SRA split for both R-type and I-type.
module multicycle_controller_alu_decoder
   import multicycle_controller_pkg::*;
(
   input  logic       is_rtype_i,
   input  logic [2:0] funct3_i,
   input  logic       bit30_i,
   output logic [3:0] alu_control_o
);

   always_comb begin
      alu_control_o = AluAdd;
      unique case (funct3_i)
         F3AddSub: alu_control_o = (is_rtype_i && bit30_i) ? AluSub : AluAdd;
         F3Sll:    alu_control_o = AluSll;
         F3Slt:    alu_control_o = AluSlt;
         F3Sltu:   alu_control_o = AluSltu;
         F3Xor:    alu_control_o = AluXor;
         F3SrlSra: alu_control_o = bit30_i ? AluSra : AluSrl;
         F3Or:     alu_control_o = AluOr;
         F3And:    alu_control_o = AluAnd;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with memory handshake, retire counter and illegal trap.
// Define XORID_EN to enable the custom XORID opcode (0001011) instead of trapping it.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [XLEN-1:0]  instr_i,
   input  logic             zero_i,
   input  logic             lt_i,
   input  logic             ltu_i,
   input  logic             mem_ready_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [1:0]       mem_size_o,
   output logic             mem_unsigned_o,
   output logic             adr_src_o,
   output logic             ir_write_o,
   output logic             pc_write_o,
   output logic             reg_write_o,
   output logic [1:0]       alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [3:0]       alu_control_o,
   output logic [2:0]       imm_src_o,
   output logic [1:0]       result_src_o,
   output logic             xorid_o,
   output logic             illegal_o,
   output logic             retire_o,
   output logic [CNT_W-1:0] instret_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             is_xorid;
   logic [3:0]       dec_alu;
   logic             unused_instr;

   assign opcode       = instr_i[6:0];
   assign funct3       = instr_i[14:12];
   assign unused_instr = ^{instr_i[XLEN-1:31], instr_i[29:15], instr_i[11:7]};

`ifdef XORID_EN
   assign is_xorid = (opcode == OpcXorid);
`else
   assign is_xorid = 1'b0;
`endif

   multicycle_controller_alu_decoder u_alu_decoder (
      .is_rtype_i    (state_q == StExeR),
      .funct3_i      (funct3),
      .bit30_i       (instr_i[30]),
      .alu_control_o (dec_alu)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StFetch;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   assign instret_d = retire_o ? instret_q + CNT_W'(1) : instret_q;
   assign instret_o = instret_q;

   // Outputs are gated by reset so an in-flight request drops asynchronously.
   always_comb begin
      state_d        = state_q;
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_size_o     = 2'b00;
      mem_unsigned_o = 1'b0;
      adr_src_o      = 1'b0;
      ir_write_o     = 1'b0;
      pc_write_o     = 1'b0;
      reg_write_o    = 1'b0;
      alu_src_a_o    = SrcAPc;
      alu_src_b_o    = SrcBRs2;
      alu_control_o  = AluAdd;
      imm_src_o      = ImmNone;
      result_src_o   = ResAluOut;
      xorid_o        = 1'b0;
      illegal_o      = 1'b0;
      retire_o       = 1'b0;
      if (rst_ni) begin
         case (state_q)
            StFetch: begin
               mem_req_o   = 1'b1;
               alu_src_b_o = SrcBFour;
               ir_write_o  = mem_ready_i;
               pc_write_o  = mem_ready_i;
               if (mem_ready_i) state_d = StDecode;
            end
            StDecode: begin
               alu_src_a_o = SrcAOldPc;
               alu_src_b_o = SrcBImm;
               imm_src_o   = ImmB;
               case (opcode)
                  OpcLoad, OpcStore: state_d = StMemAdr;
                  OpcRtype:          state_d = StExeR;
                  OpcItype:          state_d = StExeI;
                  OpcBranch:         state_d = StBranch;
                  OpcJal: begin
                     state_d   = StJal;
                     imm_src_o = ImmJ;
                  end
                  OpcJalr: begin
                     // ALUOut holds the link value OldPC+4 for the JALR cycle.
                     state_d     = StJalr;
                     alu_src_b_o = SrcBFour;
                     imm_src_o   = ImmNone;
                  end
                  OpcLui, OpcAuipc:  state_d = StUpper;
                  default:           state_d = is_xorid ? StExeI : StTrap;
               endcase
            end
            StMemAdr: begin
               alu_src_a_o = SrcARs1;
               alu_src_b_o = SrcBImm;
               imm_src_o   = (opcode == OpcStore) ? ImmS : ImmI;
               state_d     = (opcode == OpcStore) ? StMemWr : StMemRd;
            end
            StMemRd, StMemWr: begin
               mem_req_o      = 1'b1;
               mem_we_o       = (state_q == StMemWr);
               adr_src_o      = 1'b1;
               mem_size_o     = funct3[1:0];
               mem_unsigned_o = funct3[2];
               if (mem_ready_i) begin
                  state_d  = (state_q == StMemWr) ? StFetch : StMemWb;
                  retire_o = (state_q == StMemWr);
               end
            end
            StMemWb: begin
               result_src_o = ResMem;
               reg_write_o  = 1'b1;
               retire_o     = 1'b1;
               state_d      = StFetch;
            end
            StExeR: begin
               alu_src_a_o   = SrcARs1;
               alu_src_b_o   = SrcBRs2;
               alu_control_o = dec_alu;
               state_d       = StAluWb;
            end
            StExeI: begin
               alu_src_a_o   = SrcARs1;
               alu_src_b_o   = SrcBImm;
               imm_src_o     = ImmI;
               alu_control_o = is_xorid ? AluXor : dec_alu;
               xorid_o       = is_xorid;
               state_d       = StAluWb;
            end
            StAluWb: begin
               reg_write_o = 1'b1;
               retire_o    = 1'b1;
               state_d     = StFetch;
            end
            StBranch: begin
               alu_src_a_o   = SrcARs1;
               alu_src_b_o   = SrcBRs2;
               alu_control_o = AluSub;
               if (funct3[2:1] == 2'b01) begin
                  state_d = StTrap;
               end else begin
                  pc_write_o = branch_taken(funct3, zero_i, lt_i, ltu_i);
                  retire_o   = 1'b1;
                  state_d    = StFetch;
               end
            end
            StJal: begin
               alu_src_a_o  = SrcAOldPc;
               alu_src_b_o  = SrcBFour;
               result_src_o = ResAlu;
               reg_write_o  = 1'b1;
               pc_write_o   = 1'b1;
               retire_o     = 1'b1;
               state_d      = StFetch;
            end
            StJalr: begin
               alu_src_a_o = SrcARs1;
               alu_src_b_o = SrcBImm;
               imm_src_o   = ImmI;
               reg_write_o = 1'b1;
               pc_write_o  = 1'b1;
               retire_o    = 1'b1;
               state_d     = StFetch;
            end
            StUpper: begin
               imm_src_o   = ImmU;
               reg_write_o = 1'b1;
               retire_o    = 1'b1;
               state_d     = StFetch;
               if (opcode == OpcLui) begin
                  result_src_o = ResImm;
               end else begin
                  alu_src_a_o  = SrcAOldPc;
                  alu_src_b_o  = SrcBImm;
                  result_src_o = ResAlu;
               end
            end
            StTrap:  illegal_o = 1'b1;
            default: state_d = StFetch;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against a phase-level model.
module tb_multicycle_controller;

   localparam int unsigned CNT_W = 4;
   localparam int CR = 0, CI = 1, CX = 2, CLD = 3, CST = 4, CBR = 5, CJAL = 6, CJALR = 7,
                  CLUI = 8, CAUIPC = 9;
   // Phase kinds: compute, instruction fetch, data read, data write.
   localparam int PhC = 0, PhF = 1, PhR = 2, PhW = 3;
   localparam logic [24:0] RstVec = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b00, 2'b00, 4'b0000, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0};

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic [31:0]      instr = '0;
   logic             zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
   logic             mem_req, mem_we, mem_unsigned, adr_src, ir_write, pc_write, reg_write;
   logic [1:0]       mem_size, alu_src_a, alu_src_b, result_src;
   logic [3:0]       alu_control;
   logic [2:0]       imm_src;
   logic             xorid, illegal, retire;
   logic [CNT_W-1:0] instret;

   int checks = 0;
   int errors = 0;
   int model_cnt = 0;

   always #5 clk_i = ~clk_i;

   multicycle_controller #(.XLEN(32), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr), .zero_i(zero), .lt_i(lt),
      .ltu_i(ltu), .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
      .mem_size_o(mem_size), .mem_unsigned_o(mem_unsigned), .adr_src_o(adr_src),
      .ir_write_o(ir_write), .pc_write_o(pc_write), .reg_write_o(reg_write),
      .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_control_o(alu_control),
      .imm_src_o(imm_src), .result_src_o(result_src), .xorid_o(xorid),
      .illegal_o(illegal), .retire_o(retire), .instret_o(instret)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [24:0] pack_outs();
      return {mem_req, mem_we, mem_size, mem_unsigned, adr_src, ir_write, pc_write, reg_write,
              alu_src_a, alu_src_b, alu_control, imm_src, result_src, xorid, illegal, retire};
   endfunction

   task automatic set_flags(input int br_mode);
      logic [31:0] a, b;
      a = $urandom;
      if (br_mode == 1) b = a;
      else if (br_mode == 2) b = a ^ 32'h1;
      else b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      zero = (a == b);
      lt   = ($signed(a) < $signed(b));
      ltu  = (a < b);
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #2;
      rst_ni    = 1'b0;
      mem_ready = 1'b0;
      #1;
      check_eq("reset_outputs", 32'(pack_outs()), 32'(RstVec));
      check_eq("reset_instret", 32'(instret), 0);
      @(posedge clk_i);
      #2;
      rst_ni    = 1'b1;
      model_cnt = 0;
   endtask

   // mode: 0 random ready, 1 always ready, 2 three waits on read, 3 stall write then stop.
   task automatic run_instr(input logic [31:0] ins, input int cls, input int mode,
                            input int br_mode);
      int ph[$];
      int idx, cyc, wcnt, rcnt;
      logic [2:0] f3;
      logic [3:0] exp_alu;
      logic [1:0] exp_res;
      bit taken, writes, jumps, last, done_ph, is_alu;
      f3 = ins[14:12];
      idx = 0; cyc = 0; wcnt = 0; rcnt = 0;
      ph = {PhF, PhC};
      case (cls)
         CR, CI, CX: begin ph.push_back(PhC); ph.push_back(PhC); end
         CLD: begin ph.push_back(PhC); ph.push_back(PhR); ph.push_back(PhC); end
         CST: begin ph.push_back(PhC); ph.push_back(PhW); end
         default: ph.push_back(PhC);
      endcase
      case (f3)
         3'd0: exp_alu = (cls == CR && ins[30]) ? 4'b0001 : 4'b0000;
         3'd1: exp_alu = 4'b0111;
         3'd2: exp_alu = 4'b0010;
         3'd3: exp_alu = 4'b0011;
         3'd4: exp_alu = 4'b0100;
         3'd5: exp_alu = ins[30] ? 4'b1001 : 4'b1000;
         3'd6: exp_alu = 4'b0101;
         default: exp_alu = 4'b0110;
      endcase
      if (cls == CX) exp_alu = 4'b0100;
      case (cls)
         CLD: exp_res = 2'b01;
         CJAL, CAUIPC: exp_res = 2'b10;
         CLUI: exp_res = 2'b11;
         default: exp_res = 2'b00;
      endcase
      set_flags(br_mode);
      case (f3)
         3'd0: taken = zero;
         3'd1: taken = !zero;
         3'd4: taken = lt;
         3'd5: taken = !lt;
         3'd6: taken = ltu;
         default: taken = !ltu;
      endcase
      is_alu = (cls == CR || cls == CI || cls == CX);
      writes = !(cls == CST || cls == CBR);
      jumps  = (cls == CJAL || cls == CJALR || (cls == CBR && taken));
      while (idx < ph.size()) begin
         if (cyc >= 200) begin
            check_eq("timeout", cyc, 0);
            break;
         end
         @(posedge clk_i);
         #1;
         instr = ins;
         case (mode)
            1: mem_ready = 1'b1;
            2: mem_ready = (ph[idx] == PhR) ? (wcnt >= 3) : 1'b1;
            3: mem_ready = (ph[idx] != PhW);
            default: mem_ready = (ph[idx] != PhC) ? ($urandom_range(0, 2) != 0)
                                                  : ($urandom_range(0, 1) == 1);
         endcase
         #3;
         last    = (idx == ph.size() - 1);
         done_ph = (ph[idx] == PhC) || mem_ready;
         check_eq("mem_req", mem_req, ph[idx] != PhC);
         check_eq("mem_we", mem_we, ph[idx] == PhW);
         check_eq("ir_write", ir_write, ph[idx] == PhF && mem_ready);
         check_eq("pc_write", pc_write, (ph[idx] == PhF && mem_ready) || (last && jumps));
         check_eq("reg_write", reg_write, last && writes);
         check_eq("retire", retire, last && done_ph);
         check_eq("illegal", illegal, 0);
         check_eq("xorid", xorid, cls == CX && idx == ph.size() - 2);
         check_eq("instret", 32'(instret), model_cnt);
         if (ph[idx] != PhC) check_eq("adr_src", adr_src, ph[idx] >= PhR);
         if (ph[idx] >= PhR) begin
            check_eq("mem_size", mem_size, f3[1:0]);
            check_eq("mem_unsigned", mem_unsigned, f3[2]);
            if (mem_req) rcnt++;
            wcnt++;
         end
         if (last && writes) check_eq("result_src", result_src, exp_res);
         if (is_alu && idx == ph.size() - 2) begin
            check_eq("alu_control", alu_control, exp_alu);
            check_eq("alu_src_a", alu_src_a, 2'b10);
            check_eq("alu_src_b", alu_src_b, (cls == CR) ? 2'b00 : 2'b01);
         end
         if (cls == CBR && last) check_eq("branch_sub", alu_control, 4'b0001);
         if (mode == 3 && wcnt == 3) break;
         if (last && done_ph) model_cnt = (model_cnt + 1) % (1 << CNT_W);
         if (done_ph) idx++;
         cyc++;
      end
      if (mode == 2) check_eq("lw_req_cycles", rcnt, 4);
   endtask

   task automatic run_trap(input logic [31:0] ins, input bit bad_branch);
      int n;
      n = bad_branch ? 3 : 2;
      set_flags(0);
      for (int c = 0; c < n + 20; c++) begin
         @(posedge clk_i);
         #1;
         instr     = ins;
         mem_ready = (c == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
         #3;
         check_eq("trap_retire", retire, 0);
         check_eq("trap_instret", 32'(instret), model_cnt);
         check_eq("trap_illegal", illegal, c >= n);
         if (c == 0) begin
            check_eq("trap_fetch_req", mem_req, 1);
         end else begin
            check_eq("trap_mem_req", mem_req, 0);
            check_eq("trap_enables", {ir_write, pc_write, reg_write, mem_we}, 0);
         end
      end
   endtask

   task automatic run_random(input int n);
      logic [31:0] ins;
      logic [2:0] f3;
      int cls;
      for (int k = 0; k < n; k++) begin
         ins = $urandom;
`ifdef XORID_EN
         cls = $urandom_range(0, 9);
`else
         cls = $urandom_range(0, 8);
         if (cls >= CX) cls++;
`endif
         f3 = 3'($urandom_range(0, 7));
         case (cls)
            CR:  ins[6:0] = 7'b0110011;
            CI:  ins[6:0] = 7'b0010011;
            CX:  ins[6:0] = 7'b0001011;
            CLD: begin
               ins[6:0] = 7'b0000011;
               f3 = 3'($urandom_range(0, 4));
               if (f3 >= 3) f3++;
            end
            CST: begin
               ins[6:0] = 7'b0100011;
               f3 = 3'($urandom_range(0, 2));
            end
            CBR: begin
               ins[6:0] = 7'b1100011;
               f3 = 3'($urandom_range(0, 5));
               if (f3 >= 2) f3 = f3 + 3'd2;
            end
            CJAL: ins[6:0] = 7'b1101111;
            CJALR: begin
               ins[6:0] = 7'b1100111;
               f3 = 3'b000;
            end
            CLUI: ins[6:0] = 7'b0110111;
            default: ins[6:0] = 7'b0010111;
         endcase
         ins[14:12] = f3;
         run_instr(ins, cls, 0, 0);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #2;
      check_eq("por_outputs", 32'(pack_outs()), 32'(RstVec));
      check_eq("por_instret", 32'(instret), 0);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b1;

      run_instr(32'h002081B3, CR, 1, 0);
      run_instr(32'h0080A283, CLD, 2, 0);
      run_instr(32'h00208463, CBR, 1, 1);
      run_instr(32'h00208463, CBR, 1, 2);
`ifdef XORID_EN
      run_instr(32'h0000000B, CX, 1, 0);
`else
      run_trap(32'h0000000B, 1'b0);
      do_reset();
`endif
      run_random(60);

      run_trap(32'h0000007F, 1'b0);
      do_reset();
      run_trap(32'h00002063, 1'b1);
      do_reset();

      // Store stalled in its write phase, then reset mid-cycle.
      run_instr(32'h0020A423, CST, 3, 0);
      rst_ni = 1'b0;
      #1;
      check_eq("abort_mem_req", mem_req, 0);
      check_eq("abort_mem_we", mem_we, 0);
      check_eq("abort_outputs", 32'(pack_outs()), 32'(RstVec));
      check_eq("abort_instret", 32'(instret), 0);
      mem_ready = 1'b0;
      @(posedge clk_i);
      #2;
      rst_ni    = 1'b1;
      model_cnt = 0;

      run_random(20);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
